matrix_loader: RTL and testbench
================================

# matrix_loader

Upstream stage of the matrix add/subtract datapath. Accepts 8-bit signed elements one per transfer from the HPS-side bus over a valid/ready handshake, assembles two 5x5 operand matrices (200 bits each) plus the add/subtract select, and presents them with a valid/ready handshake to the add/subtract stage. It holds a completed operand set stable until the consumer accepts it, then starts the next load.

## Interface

- ELEM_W, 8, element width in bits (two's complement)
- DIM, 5, matrix dimension; N = DIM*DIM = 25 elements, matrix width MW = N*ELEM_W = 200
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- abort  in  1  synchronous clear of any load in progress
- in_data  in  ELEM_W  element being offered
- in_sel  in  1  operation select (0 = A+B, 1 = A-B); sampled only with element 0 of A
- in_valid  in  1  in_data/in_sel valid
- in_ready  out  1  loader accepts a transfer this cycle
- MatA  out  MW  operand A, element k at bits [k*ELEM_W+ELEM_W-1 : k*ELEM_W], k = row*DIM+col
- MatB  out  MW  operand B, same packing
- Select  out  1  latched operation select
- out_valid  out  1  MatA/MatB/Select complete and stable
- out_ready  in  1  downstream accepts the operand set

## Operation

- States: LOAD_A, LOAD_B, HOLD. Element counter cnt, 0..N-1 (5 bits for N=25).
- Transfer = in_valid & in_ready. in_ready = 1 in LOAD_A and LOAD_B, 0 in HOLD. It is a pure state decode, with no combinational path from in_valid or out_ready.
- LOAD_A: on a transfer, write in_data into MatA slot cnt. If cnt == 0, also latch in_sel into Select. If cnt == N-1, set cnt = 0 and go to LOAD_B; otherwise cnt++.
- LOAD_B: on a transfer, write in_data into MatB slot cnt. If cnt == N-1, set cnt = 0 and go to HOLD; otherwise cnt++.
- HOLD: out_valid = 1. MatA, MatB and Select do not change. When out_ready = 1, go to LOAD_A.
- Slots that have not yet been written keep their previous contents. The loader never clears matrices between sets.
- in_valid low in LOAD_A/LOAD_B: nothing changes, and gaps of any length are allowed.
- abort (synchronous, highest priority after reset): sets state = LOAD_A and cnt = 0 and clears out_valid. MatA, MatB and Select keep their values. A transfer in the same cycle as abort is discarded.
- out_ready asserted outside HOLD has no effect.
- No data-dependent arithmetic is done here. Elements pass bit-exact and sign is not interpreted.

## Timing

- Reset values: state = LOAD_A, cnt = 0, MatA = 0, MatB = 0, Select = 0, out_valid = 0, in_ready = 1.
- out_valid is registered. It rises the cycle after the transfer of B element N-1 and falls the cycle after the out_ready handshake.
- in_ready returns to 1 in the cycle after the out_ready handshake.
- Minimum cycle count per operand set: 2N transfer cycles + 1 handshake cycle = 51 cycles at N = 25.
- Reset asserted mid-load or in HOLD forces all reset values immediately (asynchronous). Load restarts at A element 0 on the first clk edge after deassertion.
- Outputs change only on a clk edge (or on reset assertion).

## Test plan

- Reset: assert reset mid-cycle -> out_valid = 0, in_ready = 1, MatA = MatB = 0 without any clk edge.
- Back-to-back load: send A[k] = k+1 and B[k] = 8'hF0+k with in_sel = 1 on A[0], and out_ready held 0. Required result: out_valid rises exactly one cycle after the 50th transfer; MatA[7:0] = 8'h01, MatA[199:192] = 8'h19, MatB[199:192] = 8'h08, Select = 1; in_ready = 0.
- Backpressure in HOLD: keep out_ready = 0 for 10 cycles while in_valid = 1 with changing data -> outputs are unchanged and no transfer occurs. Pulse out_ready -> out_valid = 0 and in_ready = 1 next cycle.
- Gapped input: toggle in_valid every other cycle over the full load -> results are identical to the back-to-back case, and out_valid rises one cycle after the last transfer.
- Select sampling: in_sel = 0 on A[0] and 1 on all later elements -> Select = 0 in HOLD.
- Abort: assert abort together with a valid transfer at B element 12 -> that element is not written, in_ready = 1, and the next transfer writes MatA slot 0. Completing a full 50-element load afterwards gives correct MatA and MatB.

Source files
------------

// File: rtl/matrix_loader.sv
// Collects two DIM x DIM operand matrices one element at a time and presents them,
// along with the add/subtract select, over a valid/ready handshake.
//
// state  | meaning
// LOAD_A | accepting elements of operand A (element 0 also latches the select)
// LOAD_B | accepting elements of operand B
// HOLD   | operand set complete; outputs frozen until out_ready
module matrix_loader #(
  parameter int ELEM_W = 8,
  parameter int DIM    = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       abort,
  input  logic [ELEM_W-1:0]          in_data,
  input  logic                       in_sel,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DIM*DIM*ELEM_W-1:0]  MatA,
  output logic [DIM*DIM*ELEM_W-1:0]  MatB,
  output logic                       Select,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int N  = DIM * DIM;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t        state;
  state_t        nextState;
  logic [CW-1:0] cnt;
  logic          lastElem;
  logic          writeA;
  logic          writeB;

  assign lastElem = (cnt == CW'(N - 1));

  // State register; abort overrides whatever the next-state logic chose.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LOAD_A;
    end else if (abort) begin
      state <= LOAD_A;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      LOAD_A:  if (in_valid && lastElem) nextState = LOAD_B;
      LOAD_B:  if (in_valid && lastElem) nextState = HOLD;
      HOLD:    if (out_ready) nextState = LOAD_A;
      default: nextState = LOAD_A;
    endcase
  end

  // in_ready is a pure state decode so no input reaches it combinationally.
  always_comb begin
    in_ready = 1'b0;
    writeA   = 1'b0;
    writeB   = 1'b0;
    unique case (state)
      LOAD_A: begin
        in_ready = 1'b1;
        writeA   = in_valid & ~abort;
      end
      LOAD_B: begin
        in_ready = 1'b1;
        writeB   = in_valid & ~abort;
      end
      HOLD:    in_ready = 1'b0;
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= ~abort & (nextState == HOLD);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (abort) begin
      cnt <= '0;
    end else if (writeA || writeB) begin
      cnt <= lastElem ? '0 : cnt + 1'b1;
    end
  end

  // Matrices are never cleared between sets; unwritten slots keep old data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      MatA   <= '0;
      MatB   <= '0;
      Select <= 1'b0;
    end else begin
      if (writeA) begin
        MatA[int'(cnt)*ELEM_W +: ELEM_W] <= in_data;
        if (cnt == '0) Select <= in_sel;
      end
      if (writeB) begin
        MatB[int'(cnt)*ELEM_W +: ELEM_W] <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Self-checking bench for matrix_loader: directed scenarios plus a random run,
// compared against a transfer-position model of the operand set.
module tb_matrix_loader;

  localparam int N  = 25;
  localparam int MW = 200;

  logic          clk = 1'b0;
  logic          reset;
  logic          abort;
  logic [7:0]    in_data;
  logic          in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] MatA;
  logic [MW-1:0] MatB;
  logic          Select;
  logic          out_valid;
  logic          out_ready;

  int checks   = 0;
  int failures = 0;

  // Model: pos counts accepted elements of the current set (0..2N); 2N means held.
  logic [7:0] refA[N];
  logic [7:0] refB[N];
  logic       refSel;
  int         pos;

  matrix_loader dut (
    .clk       (clk),
    .reset     (reset),
    .abort     (abort),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .MatA      (MatA),
    .MatB      (MatB),
    .Select    (Select),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [MW-1:0] packA();
    logic [MW-1:0] m;
    for (int k = 0; k < N; k++) m[k*8 +: 8] = refA[k];
    return m;
  endfunction

  function automatic logic [MW-1:0] packB();
    logic [MW-1:0] m;
    for (int k = 0; k < N; k++) m[k*8 +: 8] = refB[k];
    return m;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < N; k++) begin
      refA[k] = 8'h00;
      refB[k] = 8'h00;
    end
    refSel = 1'b0;
    pos    = 0;
  endtask

  // Called at a falling edge; drives inputs, applies one rising edge, returns at the next falling edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic s,
                       input logic ab, input logic ordy);
    in_valid  = v;
    in_data   = d;
    in_sel    = s;
    abort     = ab;
    out_ready = ordy;
    @(posedge clk);
    if (ab) begin
      pos = 0;
    end else if (pos == 2*N) begin
      if (ordy) pos = 0;
    end else if (v) begin
      if (pos < N) begin
        refA[pos] = d;
        if (pos == 0) refSel = s;
      end else begin
        refB[pos-N] = d;
      end
      pos++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    in_sel = 1'b0; out_ready = 1'b0;
    modelReset();
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_init_hs got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
    end
    checks++; if (MatA !== '0 || MatB !== '0 || Select !== 1'b0) begin
      failures++; $display("FAIL reset_init_mats got A=%h B=%h sel=%b exp zeros", MatA, MatB, Select);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 30; k++) cycle(1'b1, 8'($urandom_range(1, 255)), 1'b1, 1'b0, 1'b0);
    checks++; if (MatA !== packA() || Select !== 1'b1) begin
      failures++; $display("FAIL preload_A got A=%h sel=%b exp A=%h sel=1", MatA, Select, packA());
    end
    #2 reset = 1'b1;
    #1;
    modelReset();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_async_hs got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
    end
    checks++; if (MatA !== '0 || MatB !== '0 || Select !== 1'b0) begin
      failures++; $display("FAIL reset_async_mats got A=%h B=%h sel=%b exp zeros", MatA, MatB, Select);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 2*N; k++) begin
      cycle(1'b1, (k < N) ? 8'(k + 1) : 8'(8'hF0 + k - N), (k == 0) ? 1'b1 : 1'($urandom), 1'b0, 1'b0);
      checks++; if (out_valid !== (k == 2*N-1)) begin
        failures++; $display("FAIL b2b_valid[%0d] got=%b exp=%b", k, out_valid, (k == 2*N-1));
      end
    end
    checks++; if (MatA[7:0] !== 8'h01 || MatA[199:192] !== 8'h19) begin
      failures++; $display("FAIL b2b_A_ends got lo=%h hi=%h exp lo=01 hi=19", MatA[7:0], MatA[199:192]);
    end
    checks++; if (MatB[199:192] !== 8'h08 || Select !== 1'b1 || in_ready !== 1'b0) begin
      failures++; $display("FAIL b2b_B_sel got B_hi=%h sel=%b ready=%b exp 08 1 0", MatB[199:192], Select, in_ready);
    end
    checks++; if (MatA !== packA() || MatB !== packB()) begin
      failures++; $display("FAIL b2b_mats got A=%h B=%h exp A=%h B=%h", MatA, MatB, packA(), packB());
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 8'($urandom), 1'($urandom), 1'b0, 1'b0);
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++; $display("FAIL bp_hs[%0d] got valid=%b ready=%b exp 1 0", i, out_valid, in_ready);
      end
      checks++; if (MatA !== packA() || MatB !== packB() || Select !== refSel) begin
        failures++; $display("FAIL bp_hold[%0d] got A=%h B=%h sel=%b exp A=%h B=%h sel=%b",
                             i, MatA, MatB, Select, packA(), packB(), refSel);
      end
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release got valid=%b ready=%b exp 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_gapped();
    int sent = 0;
    for (int i = 0; i < 200 && sent < 2*N; i++) begin
      logic v = 1'(i % 2);
      cycle(v, (sent < N) ? 8'(sent + 1) : 8'(8'hF0 + sent - N),
            (sent == 0) ? 1'b1 : 1'($urandom), 1'b0, 1'($urandom));
      if (v) sent++;
      checks++; if (out_valid !== (sent == 2*N)) begin
        failures++; $display("FAIL gap_valid[%0d] got=%b exp=%b", i, out_valid, (sent == 2*N));
      end
    end
    checks++; if (MatA[7:0] !== 8'h01 || MatA[199:192] !== 8'h19 || MatB[199:192] !== 8'h08 || Select !== 1'b1) begin
      failures++; $display("FAIL gap_ends got A_lo=%h A_hi=%h B_hi=%h sel=%b exp 01 19 08 1",
                           MatA[7:0], MatA[199:192], MatB[199:192], Select);
    end
    checks++; if (MatA !== packA() || MatB !== packB()) begin
      failures++; $display("FAIL gap_mats got A=%h B=%h exp A=%h B=%h", MatA, MatB, packA(), packB());
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_select();
    for (int k = 0; k < 2*N; k++) cycle(1'b1, 8'($urandom), (k != 0), 1'b0, 1'b0);
    checks++; if (Select !== 1'b0 || out_valid !== 1'b1) begin
      failures++; $display("FAIL sel_sample got sel=%b valid=%b exp 0 1", Select, out_valid);
    end
    checks++; if (MatA !== packA() || MatB !== packB()) begin
      failures++; $display("FAIL sel_mats got A=%h B=%h exp A=%h B=%h", MatA, MatB, packA(), packB());
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_abort();
    logic [7:0] oldB12;
    logic [7:0] d2;
    for (int k = 0; k < N + 12; k++) cycle(1'b1, 8'($urandom), 1'($urandom), 1'b0, 1'b0);
    oldB12 = refB[12];
    cycle(1'b1, ~oldB12, 1'b0, 1'b1, 1'b0);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL abort_hs got ready=%b valid=%b exp 1 0", in_ready, out_valid);
    end
    checks++; if (MatB[12*8 +: 8] !== oldB12) begin
      failures++; $display("FAIL abort_B12 got=%h exp=%h", MatB[12*8 +: 8], oldB12);
    end
    d2 = 8'($urandom);
    cycle(1'b1, d2, 1'b1, 1'b0, 1'b0);
    checks++; if (MatA[7:0] !== d2 || MatB !== packB()) begin
      failures++; $display("FAIL abort_restart got A0=%h B=%h exp A0=%h B=%h", MatA[7:0], MatB, d2, packB());
    end
    for (int k = 1; k < 2*N; k++) begin
      cycle(1'b1, 8'($urandom), 1'($urandom), 1'b0, 1'b0);
      checks++; if (out_valid !== (k == 2*N-1)) begin
        failures++; $display("FAIL abort_reload_valid[%0d] got=%b exp=%b", k, out_valid, (k == 2*N-1));
      end
    end
    checks++; if (MatA !== packA() || MatB !== packB() || Select !== 1'b1) begin
      failures++; $display("FAIL abort_reload got A=%h B=%h sel=%b exp A=%h B=%h sel=1",
                           MatA, MatB, Select, packA(), packB());
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || MatA !== packA()) begin
      failures++; $display("FAIL abort_hold got valid=%b ready=%b A=%h exp 0 1 A=%h", out_valid, in_ready, MatA, packA());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom),
            $urandom_range(0, 60) == 0, $urandom_range(0, 2) == 0);
      checks++; if (out_valid !== (pos == 2*N) || in_ready !== (pos != 2*N)) begin
        failures++; $display("FAIL rnd_hs[%0d] got valid=%b ready=%b exp pos=%0d", i, out_valid, in_ready, pos);
      end
      checks++; if (MatA !== packA() || MatB !== packB() || Select !== refSel) begin
        failures++; $display("FAIL rnd_mats[%0d] got A=%h B=%h sel=%b exp A=%h B=%h sel=%b",
                             i, MatA, MatB, Select, packA(), packB(), refSel);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_gapped();
    test_select();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
